// File: rtl/sign_div.sv
// Sequential signed 32x32 divider: radix-2 restoring loop on operand magnitudes,
// one quotient bit per cycle, then a sign fix-up cycle.
module sign_div #(
    parameter int WIDTH = 32
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               enable_signal,
    input  logic [2*WIDTH-1:0] input_data,
    output logic [2*WIDTH-1:0] out_data,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [1:0]         state_dbg
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: enable_signal is sampled on a rising edge only while busy == 0
    // (IDLE); it is ignored during ITER and FIX. done pulses for one cycle with
    // busy == 0, and out_data holds that result until the next FIX edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs_mag;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;
    logic             dvs_zero;

    logic [WIDTH-1:0] in_dvd;
    logic [WIDTH-1:0] in_dvs;
    logic [WIDTH-1:0] in_dvd_mag;
    logic [WIDTH-1:0] in_dvs_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign in_dvd     = input_data[WIDTH-1:0];
    assign in_dvs     = input_data[2*WIDTH-1:WIDTH];
    assign in_dvd_mag = in_dvd[WIDTH-1] ? -in_dvd : in_dvd;
    assign in_dvs_mag = in_dvs[WIDTH-1] ? -in_dvs : in_dvs;

    assign shifted = {rem, qr[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_mag};

    // With a zero divisor every trial commits, so the remainder ends as |dividend|
    // and the sign fix-up restores the original dividend; only q needs forcing.
    assign q_fix = dvs_zero ? {WIDTH{1'b1}} : (sign_q ? -qr : qr);
    assign r_fix = sign_r ? -rem : rem;

    assign state_dbg = state;

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            qr          <= '0;
            rem         <= '0;
            dvs_mag     <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dvs_zero    <= 1'b0;
            out_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_signal) begin
                        qr          <= in_dvd_mag;
                        dvs_mag     <= in_dvs_mag;
                        sign_q      <= in_dvd[WIDTH-1] ^ in_dvs[WIDTH-1];
                        sign_r      <= in_dvd[WIDTH-1];
                        dvs_zero    <= (in_dvs == '0);
                        rem         <= '0;
                        count       <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ITER;
                    end
                end
                ITER: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        qr  <= {qr[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        qr  <= {qr[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    out_data    <= {r_fix, q_fix};
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    div_by_zero <= dvs_zero;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sign_div.sv
// Bench for sign_div: directed vector table, hand-written corner sequences and
// randomized operands checked against a plain-arithmetic signed division model.
module tb_sign_div;

    logic        clock_in = 1'b0;
    logic        reset = 1'b0;
    logic        enable_signal = 1'b0;
    logic [63:0] input_data = '0;
    logic [63:0] out_data;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [1:0]  state_dbg;

    int tests = 0;
    int failed = 0;

    sign_div #(.WIDTH(32)) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .enable_signal(enable_signal),
        .input_data   (input_data),
        .out_data     (out_data),
        .busy         (busy),
        .done         (done),
        .div_by_zero  (div_by_zero),
        .state_dbg    (state_dbg)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        logic        dz;
    } vec_t;

    logic [64:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: truncating signed division, remainder follows dividend.
    function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int sa, sb, q, r;
        sa = a;
        sb = b;
        if (sb == 0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sa == 32'sh8000_0000 && sb == -1) return {1'b0, 32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r, q};
    endfunction

    // Starts a division and waits for done; optionally pulses enable with junk
    // operands inj cycles after the start edge.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int inj,
                           output logic [63:0] res, output logic dz, output int lat);
        logic busy_bad;
        busy_bad = 1'b0;
        enable_signal = 1'b1;
        input_data = {b, a};
        @(posedge clock_in);
        #1;
        enable_signal = 1'b0;
        input_data = $urandom();
        lat = 0;
        while (!done && lat < 40) begin
            if (!busy) busy_bad = 1'b1;
            if (lat == inj) begin
                enable_signal = 1'b1;
                input_data = {32'd3, 32'd99};
            end
            @(posedge clock_in);
            #1;
            enable_signal = 1'b0;
            lat++;
            if (done && busy) busy_bad = 1'b1;
        end
        if (!done) begin
            failed++;
            tests++;
            $display("FAIL timeout: no done within %0d cycles for %h / %h", lat, a, b);
        end
        check("busy_window", {63'd0, busy_bad}, 64'd0);
        res = out_data;
        dz  = div_by_zero;
    endtask

    vec_t vecs[13];
    logic [63:0] res;
    logic        dz;
    int          lat;
    logic [64:0] e;
    logic [31:0] edges[8];
    bit          seen_done;

    initial begin
        vecs[0]  = '{32'd100,       32'd7,         64'h00000002_0000000E, 1'b0};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         64'hFFFFFFFE_FFFFFFF2, 1'b0};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  64'h00000002_FFFFFFF2, 1'b0};
        vecs[3]  = '{32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 1'b0};
        vecs[4]  = '{32'h80000000,  32'd1,         64'h00000000_80000000, 1'b0};
        vecs[5]  = '{32'd5,         32'd0,         64'h00000005_FFFFFFFF, 1'b1};
        vecs[6]  = '{32'd9,         32'd3,         64'h00000000_00000003, 1'b0};
        vecs[7]  = '{32'hFFFFFFF9,  32'd0,         64'hFFFFFFF9_FFFFFFFF, 1'b1};
        vecs[8]  = '{32'd0,         32'd5,         64'h00000000_00000000, 1'b0};
        vecs[9]  = '{32'd7,         32'd100,       64'h00000007_00000000, 1'b0};
        vecs[10] = '{32'hFFFFFFFF,  32'h80000000,  64'hFFFFFFFF_00000000, 1'b0};
        vecs[11] = '{32'h7FFFFFFF,  32'h80000000,  64'h7FFFFFFF_00000000, 1'b0};
        vecs[12] = '{32'h80000000,  32'h80000000,  64'h00000000_00000001, 1'b0};
        edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                  32'h80000001, 32'd2, 32'hFFFFFFFE};

        // Reset state
        #12;
        check("reset_out", out_data, 64'd0);
        check("reset_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock_in);
        reset = 1'b1;
        @(posedge clock_in);
        #1;

        // Directed table, back-to-back starts
        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, -1, res, dz, lat);
            check($sformatf("vec%0d_out", i), res, vecs[i].exp);
            check($sformatf("vec%0d_dz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'd33);
        end

        // done is a single-cycle pulse and out_data holds afterwards
        @(posedge clock_in);
        #1;
        check("done_pulse_width", {63'd0, done}, 64'd0);
        check("out_hold", out_data, vecs[12].exp);

        // enable while busy is ignored
        run_div(32'd100, 32'd7, 10, res, dz, lat);
        check("ignore_en_out", res, 64'h00000002_0000000E);
        check("ignore_en_lat", 64'(lat), 64'd33);

        // enable during the FIX cycle is ignored
        run_div(32'd50, 32'd6, 32, res, dz, lat);
        check("ignore_fix_out", res, 64'h00000002_00000008);
        @(posedge clock_in);
        #1;
        check("ignore_fix_idle", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-operation
        enable_signal = 1'b1;
        input_data = {32'd7, 32'd100};
        @(posedge clock_in);
        #1;
        enable_signal = 1'b0;
        repeat (15) @(posedge clock_in);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_out", out_data, 64'd0);
        check("async_rst_flags", {61'd0, busy, done, div_by_zero}, 64'd0);
        @(negedge clock_in);
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clock_in);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("no_done_after_rst", {63'd0, seen_done}, 64'd0);
        run_div(32'hFFFFFF9C, 32'hFFFFFFF9, -1, res, dz, lat);
        check("post_rst_out", res, 64'hFFFFFFFE_0000000E);

        // Randomized operands against the reference model
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, b;
            case ($urandom_range(0, 3))
                0: begin a = $urandom(); b = $urandom(); end
                1: begin a = 32'($signed($urandom_range(0, 200)) - 100);
                         b = 32'($signed($urandom_range(0, 40)) - 20); end
                2: begin a = edges[$urandom_range(0, 7)]; b = edges[$urandom_range(0, 7)]; end
                default: begin a = $urandom(); b = edges[$urandom_range(0, 3)]; end
            endcase
            exp_q.push_back(ref_div(a, b));
            run_div(a, b, -1, res, dz, lat);
            e = exp_q.pop_front();
            check($sformatf("rand%0d_out(%h/%h)", n, a, b), res, e[63:0]);
            check($sformatf("rand%0d_dz", n), {63'd0, dz}, {63'd0, e[64]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sign_div.md
# sign_div

Sequential signed 32-by-32 integer divider: the inverse counterpart of the datapath's sequential signed multiplier. It uses the same packed 64-bit operand/result convention and the same enable/busy handshake, so the two units can share operand and result buses. It computes the quotient and remainder with a radix-2 restoring shift-subtract loop, one quotient bit per cycle, on operand magnitudes with a final sign fix-up.

## Interface
- WIDTH, 32, operand width. All data buses are 2*WIDTH bits wide.
- clock_in  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset, asynchronous, active-low (reset == 0 clears all state immediately).
- enable_signal  in  1  start request, sampled on the rising edge.
- input_data  in  64  operands: [31:0] = dividend, [63:32] = divisor, both two's complement. Sampled only on the start edge.
- out_data  out  64  result: [31:0] = quotient, [63:32] = remainder. Holds its value between operations.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse; out_data is valid in the same cycle.
- div_by_zero  out  1  set with done when divisor == 0; holds until the next start.

## Operation
- States: IDLE, ITER, FIX.
- IDLE, enable_signal == 1 at an edge:
  - capture |dividend|, |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend);
  - clear the partial remainder (33-bit), clear the 5-bit counter, clear div_by_zero;
  - busy <= 1; go to ITER.
- Magnitudes are computed as 32-bit unsigned values, so |-2^31| = 0x80000000 is exact.
- ITER, one step per edge:
  - shift {partial remainder, quotient register} left by 1, with the dividend MSB entering the remainder;
  - trial = remainder - |divisor| (33-bit);
  - if trial >= 0, commit it and set quotient LSB = 1; otherwise keep the remainder and set quotient LSB = 0;
  - counter increments; after the step where counter == 31, go to FIX.
- FIX, one edge:
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r (32-bit wrap);
  - write out_data; busy <= 0; done <= 1; div_by_zero <= (divisor == 0); go to IDLE.
- Semantics: truncation toward zero; the remainder takes the dividend's sign; dividend == quotient*divisor + remainder (mod 2^32).
- Divide by zero: the same loop runs with no special path. The result is forced to quotient = 0xFFFFFFFF and remainder = dividend (original signed value), with div_by_zero = 1.
- Overflow, -2^31 / -1: quotient = 0x80000000, remainder = 0, no flag.
- enable_signal while busy is ignored. There is no restart and operands are not re-sampled.
- enable_signal during the FIX cycle is also ignored. A new start is accepted on the first edge with busy == 0.

## Timing
- Reset values: out_data = 0, busy = 0, done = 0, div_by_zero = 0, state = IDLE, counter = 0.
- Reset asserted mid-operation aborts immediately. The result is discarded and no done pulse is issued.
- Start edge E0 → busy is high from E0 through the cycle before E33.
- ITER occupies edges E1..E32 (32 steps). FIX is edge E33.
- done is high for exactly the one cycle after E33, together with busy = 0 and the new out_data.
- Latency is 33 clock cycles from start sample to result. Throughput is one division per 34 cycles with back-to-back enable.
- done is never high while busy is high.
- out_data changes only at a FIX edge or at reset.

## Test plan
- 100 / 7 → out_data = 0x00000002_0000000E, done after 33 cycles, div_by_zero = 0.
- -100 / 7 → quotient 0xFFFFFFF2, remainder 0xFFFFFFFE. 100 / -7 → quotient 0xFFFFFFF2, remainder 0x00000002.
- 0x80000000 / 0xFFFFFFFF → out_data = 0x00000000_80000000, no flag. 0x80000000 / 1 → quotient 0x80000000, remainder 0.
- 5 / 0 → out_data = 0x00000005_FFFFFFFF, div_by_zero = 1. A following 9 / 3 clears the flag and gives 0x00000000_00000003.
- Start 100 / 7, then pulse enable with other operands at cycle 10 → ignored, result 0x00000002_0000000E. Back-to-back start on the edge after done is accepted.
- Start a division, assert reset (0) at cycle 15 → busy, done and out_data go to 0 asynchronously, and no done pulse follows. A new start after reset release completes correctly.
